// File: rtl/prbs_bert_seq.sv
// BER sweep sequencer: steps one PRBS checker through every pattern selected in a mask,
// resetting it, waiting for lock and counting error bits over a fixed window per pattern.
module prbs_bert_seq #(
  parameter int C_RST_CLK_NUM      = 4,
  parameter int C_LOCK_TIMEOUT_CLK = 1000,
  parameter int C_MEAS_CLK_NUM     = 10000
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        START_I,
  input  logic        ABORT_I,
  input  logic [15:0] PATTERN_MASK_I,
  input  logic [6:0]  DATA_WIDTH_I,
  output logic [3:0]  PATTERN_O,
  output logic [6:0]  DATA_WIDTH_O,
  output logic        CHK_RST_O,
  input  logic        CHK_LOCKED_I,
  input  logic [31:0] CHK_ERR_BIT_NUM_I,
  output logic        BUSY_O,
  output logic        DONE_O,
  output logic        RES_VALID_O,
  output logic [3:0]  RES_PATTERN_O,
  output logic [31:0] RES_ERR_O,
  output logic [1:0]  RES_STATUS_O,
  output logic [31:0] TOTAL_ERR_O
);

  localparam int RST_W  = $clog2(C_RST_CLK_NUM + 1);
  localparam int LOCK_W = $clog2(C_LOCK_TIMEOUT_CLK + 1);
  localparam int MEAS_W = $clog2(C_MEAS_CLK_NUM + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(C_RST_CLK_NUM - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(C_LOCK_TIMEOUT_CLK - 1);
  localparam logic [MEAS_W-1:0] MEAS_LAST = MEAS_W'(C_MEAS_CLK_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_RST, S_LOCK, S_SNAP, S_MEAS, S_REPORT, S_DONE
  } state_t;

  state_t state;

  logic [15:0]       rem_mask;
  logic [31:0]       base;
  logic [RST_W-1:0]  rst_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [MEAS_W-1:0] meas_cnt;

  logic [3:0]  low_idx;
  logic [31:0] err_delta;
  logic        rpt_go;
  logic [31:0] rpt_err;
  logic [1:0]  rpt_status;
  logic [32:0] total_sum;
  logic [31:0] total_sat;

  // Scanning downwards leaves the lowest set bit as the final winner.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rem_mask[i]) low_idx = 4'(i);
    end
  end

  assign err_delta = CHK_ERR_BIT_NUM_I - base;

  always_comb begin
    rpt_go     = 1'b0;
    rpt_err    = '0;
    rpt_status = 2'd0;
    case (state)
      S_LOCK: begin
        if (!CHK_LOCKED_I && lock_cnt == LOCK_LAST) begin
          rpt_go     = 1'b1;
          rpt_status = 2'd2;
        end
      end
      S_MEAS: begin
        if (!CHK_LOCKED_I) begin
          rpt_go     = 1'b1;
          rpt_err    = err_delta;
          rpt_status = 2'd3;
        end else if (meas_cnt == MEAS_LAST) begin
          rpt_go     = 1'b1;
          rpt_err    = err_delta;
          rpt_status = (err_delta == '0) ? 2'd0 : 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign total_sum = {1'b0, TOTAL_ERR_O} + {1'b0, rpt_err};
  assign total_sat = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state         <= S_IDLE;
      rem_mask      <= '0;
      base          <= '0;
      rst_cnt       <= '0;
      lock_cnt      <= '0;
      meas_cnt      <= '0;
      PATTERN_O     <= '0;
      DATA_WIDTH_O  <= '0;
      CHK_RST_O     <= 1'b0;
      BUSY_O        <= 1'b0;
      DONE_O        <= 1'b0;
      RES_VALID_O   <= 1'b0;
      RES_PATTERN_O <= '0;
      RES_ERR_O     <= '0;
      RES_STATUS_O  <= '0;
      TOTAL_ERR_O   <= '0;
    end else begin
      DONE_O      <= 1'b0;
      RES_VALID_O <= 1'b0;
      if (ABORT_I && state != S_IDLE) begin
        state     <= S_IDLE;
        CHK_RST_O <= 1'b0;
        BUSY_O    <= 1'b0;
      end else if (rpt_go) begin
        state         <= S_REPORT;
        RES_VALID_O   <= 1'b1;
        RES_PATTERN_O <= PATTERN_O;
        RES_ERR_O     <= rpt_err;
        RES_STATUS_O  <= rpt_status;
        TOTAL_ERR_O   <= total_sat;
      end else begin
        case (state)
          S_IDLE: begin
            if (START_I && !ABORT_I) begin
              rem_mask     <= PATTERN_MASK_I;
              DATA_WIDTH_O <= DATA_WIDTH_I;
              TOTAL_ERR_O  <= '0;
              BUSY_O       <= 1'b1;
              state        <= S_SEL;
            end
          end
          S_SEL: begin
            if (rem_mask == '0) begin
              DONE_O <= 1'b1;
              state  <= S_DONE;
            end else begin
              PATTERN_O <= low_idx;
              rem_mask  <= rem_mask & (rem_mask - 16'd1);
              rst_cnt   <= '0;
              CHK_RST_O <= 1'b1;
              state     <= S_RST;
            end
          end
          S_RST: begin
            if (rst_cnt == RST_LAST) begin
              CHK_RST_O <= 1'b0;
              lock_cnt  <= '0;
              state     <= S_LOCK;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_LOCK: begin
            if (CHK_LOCKED_I) state <= S_SNAP;
            else lock_cnt <= lock_cnt + 1'b1;
          end
          S_SNAP: begin
            base     <= CHK_ERR_BIT_NUM_I;
            meas_cnt <= '0;
            state    <= S_MEAS;
          end
          S_MEAS:   meas_cnt <= meas_cnt + 1'b1;
          S_REPORT: state <= S_SEL;
          S_DONE: begin
            BUSY_O <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_bert_seq.sv
// Bench for prbs_bert_seq: a behavioural PRBS checker model, a result scoreboard,
// a table of sweep vectors and hand sequences for timing, abort and reset cases.
module tb_prbs_bert_seq;

  localparam int RST_N   = 4;
  localparam int LOCK_TO = 50;
  localparam int MEAS_N  = 1000;

  logic        CLK_I, RST_I, START_I, ABORT_I;
  logic [15:0] PATTERN_MASK_I;
  logic [6:0]  DATA_WIDTH_I;
  logic [3:0]  PATTERN_O;
  logic [6:0]  DATA_WIDTH_O;
  logic        CHK_RST_O, CHK_LOCKED_I;
  logic [31:0] CHK_ERR_BIT_NUM_I;
  logic        BUSY_O, DONE_O, RES_VALID_O;
  logic [3:0]  RES_PATTERN_O;
  logic [31:0] RES_ERR_O;
  logic [1:0]  RES_STATUS_O;
  logic [31:0] TOTAL_ERR_O;

  prbs_bert_seq #(
    .C_RST_CLK_NUM(RST_N),
    .C_LOCK_TIMEOUT_CLK(LOCK_TO),
    .C_MEAS_CLK_NUM(MEAS_N)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .ABORT_I(ABORT_I),
    .PATTERN_MASK_I(PATTERN_MASK_I), .DATA_WIDTH_I(DATA_WIDTH_I),
    .PATTERN_O(PATTERN_O), .DATA_WIDTH_O(DATA_WIDTH_O), .CHK_RST_O(CHK_RST_O),
    .CHK_LOCKED_I(CHK_LOCKED_I), .CHK_ERR_BIT_NUM_I(CHK_ERR_BIT_NUM_I),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O), .RES_VALID_O(RES_VALID_O),
    .RES_PATTERN_O(RES_PATTERN_O), .RES_ERR_O(RES_ERR_O),
    .RES_STATUS_O(RES_STATUS_O), .TOTAL_ERR_O(TOTAL_ERR_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [15:0] mask;
    logic [6:0]  width;
    bit          no_lock;
    logic [31:0] inj;
    int          drop_at;
    logic [31:0] preset;
    logic [1:0]  f_st;
    logic [31:0] f_err;
    logic [1:0]  r_st;
    logic [31:0] r_err;
  } vec_t;

  typedef struct {
    logic [3:0]  pat;
    logic [31:0] err;
    logic [1:0]  st;
    logic [31:0] total;
  } res_t;

  res_t sb[$];
  res_t e_res;
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  bit          m_no_lock = 1'b0;
  bit          m_dropped = 1'b0;
  logic [31:0] m_inj     = '0;
  logic [31:0] m_preset  = '0;
  int          m_drop_at = 0;
  int          m_lk      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Checker model: reset clears lock and loads the error counter; it locks on the first
  // free cycle, injects errors 100 cycles into the window and can drop lock once.
  initial begin
    CHK_LOCKED_I      = 1'b0;
    CHK_ERR_BIT_NUM_I = '0;
    forever begin
      @(posedge CLK_I); #1;
      if (CHK_RST_O) begin
        CHK_LOCKED_I      = 1'b0;
        m_dropped         = 1'b0;
        m_lk              = 0;
        CHK_ERR_BIT_NUM_I = m_preset;
      end else if (!CHK_LOCKED_I && !m_no_lock && !m_dropped) begin
        CHK_LOCKED_I = 1'b1;
        m_lk         = 0;
      end else if (CHK_LOCKED_I) begin
        m_lk++;
        if (m_lk == 102) CHK_ERR_BIT_NUM_I = CHK_ERR_BIT_NUM_I + m_inj;
        if (m_drop_at != 0 && m_lk == 2 + m_drop_at) begin
          CHK_LOCKED_I = 1'b0;
          m_dropped    = 1'b1;
          m_drop_at    = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK_I);
      if (DONE_O) done_cnt++;
      if (RES_VALID_O) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: pattern %0d err 0x%08h status %0d, no result expected",
                   RES_PATTERN_O, RES_ERR_O, RES_STATUS_O);
        end else begin
          e_res = sb.pop_front();
          check("res_pattern", 32'(RES_PATTERN_O), 32'(e_res.pat));
          check("res_err", RES_ERR_O, e_res.err);
          check("res_status", 32'(RES_STATUS_O), 32'(e_res.st));
          check("res_total", TOTAL_ERR_O, e_res.total);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic outs_zero(input string tag);
    check({tag, "_pat_width"}, 32'({PATTERN_O, DATA_WIDTH_O}), 32'd0);
    check({tag, "_flags"}, 32'({BUSY_O, DONE_O, RES_VALID_O, CHK_RST_O, RES_STATUS_O, RES_PATTERN_O}), 32'd0);
    check({tag, "_res_err"}, RES_ERR_O, 32'd0);
    check({tag, "_total"}, TOTAL_ERR_O, 32'd0);
  endtask

  task automatic pulse_start(input logic [15:0] mask, input logic [6:0] width);
    @(posedge CLK_I); #1;
    START_I = 1'b1; PATTERN_MASK_I = mask; DATA_WIDTH_I = width;
    @(posedge CLK_I); #1;
    START_I = 1'b0; PATTERN_MASK_I = 16'hFFFF; DATA_WIDTH_I = ~width;
  endtask

  task automatic wait_idle(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge CLK_I);
      if (!BUSY_O) got = 1'b1;
    end
    check({tag, "_idle_reached"}, 32'(got), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] tot;
    bit          first;
    bit          got;
    int          d0;
    res_t        r;
    m_no_lock = v.no_lock; m_inj = v.inj; m_drop_at = v.drop_at; m_preset = v.preset;
    tot   = '0;
    first = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (v.mask[b]) begin
        r.pat   = 4'(b);
        r.st    = first ? v.f_st : v.r_st;
        r.err   = first ? v.f_err : v.r_err;
        tot     = sat_add(tot, r.err);
        r.total = tot;
        sb.push_back(r);
        first   = 1'b0;
      end
    end
    d0 = done_cnt;
    pulse_start(v.mask, v.width);
    check("busy_after_start", 32'(BUSY_O), 32'd1);
    // A second start while busy must be ignored.
    @(posedge CLK_I); #1; START_I = 1'b1;
    @(posedge CLK_I); #1; START_I = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge CLK_I); #1;
      if (done_cnt != d0) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    repeat (4) @(posedge CLK_I);
    #1;
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_idle", 32'(BUSY_O), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("width_latched", 32'(DATA_WIDTH_O), 32'(v.width));
    check("total_err", TOTAL_ERR_O, tot);
  endtask

  initial begin
    int  n;
    bit  got;
    int  d0;
    res_t r;

    //          mask      width   nolk inj            drop pre            f_st  f_err          r_st  r_err
    vecs[0] = '{16'h0003, 7'd32,  0,   32'd0,         0,   32'd0,         2'd0, 32'd0,         2'd0, 32'd0};
    vecs[1] = '{16'h0002, 7'd16,  0,   32'd1,         0,   32'd0,         2'd1, 32'd1,         2'd1, 32'd1};
    vecs[2] = '{16'h0200, 7'd8,   1,   32'd0,         0,   32'd0,         2'd2, 32'd0,         2'd2, 32'd0};
    vecs[3] = '{16'h0005, 7'd64,  0,   32'd3,         300, 32'd0,         2'd3, 32'd3,         2'd1, 32'd3};
    vecs[4] = '{16'h0000, 7'd1,   0,   32'd0,         0,   32'd0,         2'd0, 32'd0,         2'd0, 32'd0};
    vecs[5] = '{16'h8000, 7'd127, 0,   32'h20,        0,   32'hFFFFFFF0,  2'd1, 32'h20,        2'd1, 32'h20};
    vecs[6] = '{16'h0003, 7'd40,  0,   32'hFFFFFFF0,  0,   32'd0,         2'd1, 32'hFFFFFFF0,  2'd1, 32'hFFFFFFF0};

    RST_I = 1'b1; START_I = 1'b0; ABORT_I = 1'b0;
    PATTERN_MASK_I = '0; DATA_WIDTH_I = '0;
    repeat (3) @(posedge CLK_I);
    #1;
    outs_zero("reset");
    RST_I = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Empty mask: DONE two cycles after START, BUSY falls the cycle after DONE.
    pulse_start(16'h0000, 7'd5);
    check("empty_sel_done", 32'({BUSY_O, DONE_O}), 32'b10);
    @(posedge CLK_I); #1;
    check("empty_done", 32'({BUSY_O, DONE_O}), 32'b11);
    @(posedge CLK_I); #1;
    check("empty_after_done", 32'({BUSY_O, DONE_O}), 32'b00);

    // Reset hold length and lock-timeout latency.
    m_no_lock = 1'b1; m_inj = '0; m_drop_at = 0; m_preset = '0;
    r.pat = 4'd9; r.err = '0; r.st = 2'd2; r.total = '0;
    sb.push_back(r);
    pulse_start(16'h0200, 7'd20);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK_I);
      if (CHK_RST_O) got = 1'b1;
    end
    check("rst_seen", 32'(got), 32'd1);
    n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_I);
      if (!CHK_RST_O) break;
      n++;
    end
    check("rst_len", 32'(n), 32'(RST_N));
    n = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge CLK_I);
      n++;
      if (RES_VALID_O) got = 1'b1;
    end
    check("timeout_latency", 32'(n), 32'(LOCK_TO));
    wait_idle("timeout");

    // Abort while the checker is held in reset.
    m_no_lock = 1'b0;
    d0 = done_cnt;
    pulse_start(16'h0001, 7'd12);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK_I);
      if (CHK_RST_O) got = 1'b1;
    end
    check("abort_rst_seen", 32'(got), 32'd1);
    @(posedge CLK_I); #1; ABORT_I = 1'b1;
    @(posedge CLK_I); #1; ABORT_I = 1'b0;
    check("abort_state", 32'({BUSY_O, CHK_RST_O}), 32'b00);
    repeat (30) @(posedge CLK_I);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Synchronous reset in the middle of a measurement window.
    pulse_start(16'h0010, 7'h55);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK_I);
      if (CHK_RST_O) got = 1'b1;
    end
    repeat (30) @(posedge CLK_I);
    #1;
    check("meas_pattern", 32'({BUSY_O, PATTERN_O, DATA_WIDTH_O}), 32'({1'b1, 4'd4, 7'h55}));
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    outs_zero("rst_meas");
    RST_I = 1'b0;
    repeat (5) @(posedge CLK_I);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_bert_seq.md
# prbs_bert_seq

Sequencer that drives one PRBS checker instance through a bit-error-rate sweep. On a start pulse it runs each pattern selected in a mask in turn: it sets the checker pattern and width, resets the checker, waits for lock, measures errors over a fixed window, and reports a result per pattern. It sits between a register/control interface and the checker's `PATTERN_I`, `DATA_WIDTH_I`, `RST_I`, `CHK_LOCKED_O` and `CHK_ERR_BIT_NUM_O` ports.

## Interface
- `C_RST_CLK_NUM`, 4: number of cycles `CHK_RST_O` is held high per pattern (≥1).
- `C_LOCK_TIMEOUT_CLK`, 1000: maximum number of cycles to wait for checker lock (≥1).
- `C_MEAS_CLK_NUM`, 10000: length of the measurement window in cycles (≥1).

Ports:
- `CLK_I`, in, 1: the single clock.
- `RST_I`, in, 1: reset, synchronous, active-high.
- `START_I`, in, 1: start pulse; accepted only in IDLE.
- `ABORT_I`, in, 1: abandons the sweep; has priority over all other inputs except `RST_I`.
- `PATTERN_MASK_I`, in, 16: bit n set means run pattern n; latched at start.
- `DATA_WIDTH_I`, in, 7: lane width; latched at start.
- `PATTERN_O`, out, 4: drives the checker's `PATTERN_I`.
- `DATA_WIDTH_O`, out, 7: drives the checker's `DATA_WIDTH_I`.
- `CHK_RST_O`, out, 1: drives the checker's reset.
- `CHK_LOCKED_I`, in, 1: checker lock indication.
- `CHK_ERR_BIT_NUM_I`, in, 32: checker's cumulative error-bit count.
- `BUSY_O`, out, 1: high whenever the FSM is not in IDLE.
- `DONE_O`, out, 1: one-cycle pulse when the sweep completes normally.
- `RES_VALID_O`, out, 1: one-cycle pulse per completed pattern.
- `RES_PATTERN_O`, out, 4: pattern the result refers to.
- `RES_ERR_O`, out, 32: error bits counted in the window.
- `RES_STATUS_O`, out, 2: 0 = pass, 1 = errors seen, 2 = lock timeout, 3 = lock lost during the window.
- `TOTAL_ERR_O`, out, 32: sum of `RES_ERR_O` over the sweep; saturates at 0xFFFFFFFF.

## Operation
- **Reset values.** All outputs are 0 and the FSM is in IDLE.
- **IDLE.** `START_I` latches the mask to `rem_mask`, latches the width to `DATA_WIDTH_O`, clears `TOTAL_ERR_O`, and moves to SEL.
- **SEL** (1 cycle).
  - If `rem_mask` is 0, go to DONE.
  - Otherwise take the lowest set bit n: `PATTERN_O`=n, clear bit n, go to RST.
- **RST.** `CHK_RST_O`=1 for exactly `C_RST_CLK_NUM` cycles, then go to LOCK.
- **LOCK.**
  - `CHK_LOCKED_I`=1 goes to SNAP.
  - After `C_LOCK_TIMEOUT_CLK` cycles with no lock, go to REPORT with status 2 and `RES_ERR_O`=0.
- **SNAP** (1 cycle). `base` is set to `CHK_ERR_BIT_NUM_I`.
- **MEAS.** Lasts `C_MEAS_CLK_NUM` cycles.
  - On the last cycle, `RES_ERR_O` = `CHK_ERR_BIT_NUM_I` − `base`, modulo 2^32. Status is 0 if the result is zero, otherwise 1.
  - If `CHK_LOCKED_I`=0 on any MEAS cycle: go to REPORT immediately with the difference taken at that cycle and status 3.
- **REPORT** (1 cycle). `RES_VALID_O`=1, and `TOTAL_ERR_O` is updated with saturating addition. Then go to SEL.
- **DONE** (1 cycle). `DONE_O`=1, then go to IDLE.
- **Result holding.** `RES_*` outputs hold their value until the next REPORT.
- **ABORT_I** in any non-IDLE state: the next state is IDLE and `CHK_RST_O`=0. No `RES_VALID_O` and no `DONE_O` are issued. `TOTAL_ERR_O` holds its value.
- **`START_I` while busy** is ignored.
- **Mid-sweep input changes.** Changes to `PATTERN_MASK_I` or `DATA_WIDTH_I` during a sweep have no effect.

## Timing
- START sampled at edge k: `BUSY_O`=1 and state=SEL after edge k+1.
- First `CHK_RST_O`=1 after edge k+2, held for `C_RST_CLK_NUM` edges.
- A zero mask gives `DONE_O` high for the cycle after edge k+2, with no `RES_VALID_O`.
- Per pattern with lock at the first LOCK cycle: SEL, then `C_RST_CLK_NUM` RST cycles, then 1 LOCK, 1 SNAP, `C_MEAS_CLK_NUM` MEAS and 1 REPORT. That is 4 + `C_RST_CLK_NUM` + `C_MEAS_CLK_NUM` cycles.
- `RES_VALID_O` and the updated `TOTAL_ERR_O` are visible in the same cycle.
- `BUSY_O` falls in the cycle after DONE.
- `RST_I` mid-sweep: all outputs return to reset values after that edge.
- **Counter widths.** Each counter has width clog2(param+1). Counters clear on every state entry.

## Test plan
- **Clean two-pattern sweep.** Mask=0x0003, ideal gen loopback, `C_MEAS_CLK_NUM`=1000 → two `RES_VALID_O` pulses with patterns 0 then 1, status 0, err 0. Then `DONE_O`, then `BUSY_O`=0.
- **Injected error.** Mask=0x0002; force one corrupted word during MEAS → status 1, `RES_ERR_O` equals the checker's delta (e.g. 1), and `TOTAL_ERR_O` matches it.
- **Lock timeout.** Mask=0x0200, `CHK_LOCKED_I` tied to 0, `C_LOCK_TIMEOUT_CLK`=50 → `RES_VALID_O` exactly 50 cycles after LOCK entry, status 2, err 0.
- **Lock loss.** Drop `CHK_LOCKED_I` 300 cycles into MEAS → immediate REPORT with status 3; the sweep continues to the next masked pattern.
- **Empty mask and busy start.** Mask=0 → `DONE_O` 2 cycles after START, no results. A second `START_I` while busy is ignored.
- **Abort and reset.** `ABORT_I` in RST → IDLE, `CHK_RST_O`=0, no `DONE_O`. `RST_I` in MEAS → all outputs 0 on the next cycle. Counter wrap: base=0xFFFFFFF0 and end=0x00000010 give `RES_ERR_O`=0x20.
